// File: rtl/alu.sv
// 8-bit accumulator ALU for the processor datapath.
// One accumulator register (AC) is updated on every rising edge of Clk.
// The update is chosen by priority: reset, then bus load, then increment,
// then the alu_op operation on AC and the bus value.
// AC drives dout directly from the register, so no input reaches dout
// combinationally.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] BusOut,
  input  logic             Wen,
  input  logic             INC,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] dout
);

  // alu_op encoding
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [WIDTH-1:0] ac_q;
  logic [WIDTH-1:0] ac_d;
  logic [WIDTH-1:0] op_result;

  // Result of the selected operation. Sums and differences are
  // truncated to WIDTH bits, so carry and borrow are discarded.
  always_comb begin
    op_result = ac_q;
    unique case (alu_op)
      OP_NOP:  op_result = ac_q;
      OP_ADD:  op_result = ac_q + BusOut;
      OP_SUB:  op_result = ac_q - BusOut;
      OP_AND:  op_result = ac_q & BusOut;
      OP_OR:   op_result = ac_q | BusOut;
      OP_XOR:  op_result = ac_q ^ BusOut;
      OP_NOT:  op_result = ~ac_q;
      OP_PASS: op_result = BusOut;
      default: op_result = ac_q;
    endcase
  end

  // Next AC value. Wen has priority over INC, and INC has priority over alu_op.
  // Reset is applied in the register itself.
  always_comb begin
    ac_d = op_result;
    if (Wen) begin
      ac_d = BusOut;
    end else if (INC) begin
      ac_d = ac_q + WIDTH'(1);
    end
  end

  // Accumulator register with a synchronous, active-high clear.
  always_ff @(posedge Clk) begin
    if (RST) begin
      ac_q <= '0;
    end else begin
      ac_q <= ac_d;
    end
  end

  assign dout = ac_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking testbench for the accumulator ALU.
// It applies the directed sequence first and then a run of random cycles.
// Expected values are either written out as constants or produced by a
// modulo-256 reference model.
module tb_alu;

  logic       Clk;
  logic       RST;
  logic [7:0] BusOut;
  logic       Wen;
  logic       INC;
  logic [2:0] alu_op;
  logic [7:0] dout;

  int tests_run = 0;
  int tests_failed = 0;
  int model_ac = 0;

  alu #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .RST    (RST),
    .BusOut (BusOut),
    .Wen    (Wen),
    .INC    (INC),
    .alu_op (alu_op),
    .dout   (dout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain integer arithmetic modulo 256, using the
  // control priority and the operation table.
  function automatic int ref_next(int ac, bit rst, bit wen, bit inc, int op, int bus);
    if (rst) return 0;
    if (wen) return bus;
    if (inc) return (ac + 1) % 256;
    case (op)
      0: return ac;
      1: return (ac + bus) % 256;
      2: return (ac - bus + 256) % 256;
      3: return ac & bus;
      4: return ac | bus;
      5: return ac ^ bus;
      6: return 255 - ac;
      default: return bus;
    endcase
  endfunction

  // Drives one set of inputs and waits for one rising edge.
  // The output is sampled 1 time unit after the edge and compared with exp.
  task automatic step(input string tag, input bit rst, input bit wen, input bit inc,
                      input int op, input int bus, input int exp);
    RST = rst; Wen = wen; INC = inc; alu_op = 3'(op); BusOut = 8'(bus);
    @(posedge Clk);
    #1;
    model_ac = ref_next(model_ac, rst, wen, inc, op, bus);
    tests_run++;
    assert (dout === 8'(exp)) else begin
      tests_failed++;
      $error("FAIL %s: dout=%0d expected=%0d", tag, dout, exp);
    end
    $display("[TB] %-8s rst=%0d wen=%0d inc=%0d op=%0d bus=%0d -> dout=%0d (exp %0d)",
             tag, rst, wen, inc, op, bus, dout, exp);
  endtask

  initial begin
    int r_bus, r_op, hold;
    bit r_rst, r_wen, r_inc;
    RST = 1'b0; Wen = 1'b0; INC = 1'b0; alu_op = 3'd0; BusOut = 8'd0;
    @(negedge Clk);

    // Reset takes priority over the INC and BusOut values applied with it.
    step("reset", 1, 0, 1, 0, 35, 0);

    // Load, then the arithmetic and logic operations.
    step("load12", 0, 1, 0, 0, 12, 12);
    step("add13", 0, 0, 0, 1, 13, 25);
    step("sub3a", 0, 0, 0, 2, 3, 22);
    step("sub3b", 0, 0, 0, 2, 3, 19);
    step("and5", 0, 0, 0, 3, 5, 1);
    step("or6", 0, 0, 0, 4, 6, 7);
    step("xorff", 0, 0, 0, 5, 255, 8'hF8);
    step("not", 0, 0, 0, 6, 170, 8'h07);
    step("pass", 0, 0, 0, 7, 77, 77);

    // Increment across the wrap point, and the wrapping ADD and SUB cases.
    step("load254", 0, 1, 0, 0, 254, 254);
    step("inc1", 0, 0, 1, 0, 0, 255);
    step("inc2", 0, 0, 1, 0, 0, 0);
    step("inc3", 0, 0, 1, 0, 0, 1);
    step("load200", 0, 1, 0, 0, 200, 200);
    step("addwrap", 0, 0, 0, 1, 100, 44);
    step("load0", 0, 1, 0, 0, 0, 0);
    step("subwrap", 0, 0, 0, 2, 1, 255);

    // Priority among the control inputs.
    step("prio_rst", 1, 1, 1, 1, 88, 0);
    step("prio_wen", 0, 1, 1, 0, 9, 9);
    step("prio_inc", 0, 0, 1, 1, 50, 10);

    // NOP holds AC while BusOut toggles.
    for (int i = 0; i < 5; i++) begin
      step("nop", 0, 0, 0, 0, (i % 2 == 0) ? 8'h55 : 8'hAA, 10);
    end

    // Random cycles checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_rst = ($urandom_range(0, 9) == 0);
      r_wen = ($urandom_range(0, 5) == 0);
      r_inc = ($urandom_range(0, 5) == 0);
      r_op  = int'($urandom_range(0, 7));
      r_bus = int'($urandom_range(0, 255));
      hold  = ref_next(model_ac, r_rst, r_wen, r_inc, r_op, r_bus);
      step("random", r_rst, r_wen, r_inc, r_op, r_bus, hold);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
